// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the cascaded mod-N counter family.
//
// Contents:
//   DirUp / DirDn    - encoding of the per-digit direction input (1 = up, 0 = down)
//   digit_width_ok() - true when an M-bit digit can hold every value 0..N-1
package counter_pkg;

    localparam logic DirUp = 1'b1;
    localparam logic DirDn = 1'b0;

    // An M-bit digit holds values up to 2**M-1, so it covers mod-N when 2**M >= N.
    function automatic bit digit_width_ok(input int unsigned n, input int unsigned m);
        return (64'd1 << m) >= 64'(n);
    endfunction

endpackage

// File: rtl/counter_digit.sv
// counter_digit: one mod-N up/down digit of a cascaded counter.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset, clears the digit to 0
//   load    in   load ld_val this edge (reset wins, cin ignored)
//   ld_val  in   [M-1:0] value to load; the caller guarantees ld_val < N
//   cin     in   count permission for this edge
//   up      in   direction, DirUp = count up, DirDn = count down
//   q       out  [M-1:0] current digit value
//   cout    out  digit sits at its wrap point for the current direction
//                (N-1 going up, 0 going down); not qualified by cin
module counter_digit
    import counter_pkg::*;
#(
    parameter int unsigned N = 10,
    parameter int unsigned M = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [M-1:0] ld_val,
    input  logic         cin,
    input  logic         up,
    output logic [M-1:0] q,
    output logic         cout
);

    localparam logic [M-1:0] Max = M'(N - 1);

    logic [M-1:0] q_q;
    logic [M-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = ld_val;
        end else if (cin) begin
            unique case (up)
                DirUp:   q_d = (q_q == Max) ? '0 : q_q + 1'b1;
                DirDn:   q_d = (q_q == '0) ? Max : q_q - 1'b1;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign cout = (up == DirUp) ? (q_q == Max) : (q_q == '0);

endmodule

// File: rtl/counter_cascade_n.sv
// counter_cascade_n: D cascaded mod-N up/down digits forming a mod-N**D counter
// with synchronous parallel load, direction control and terminal-count flags.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset (clears digits and load_err)
//   enable    in   count enable for the whole chain
//   up        in   1 = count up, 0 = count down
//   load      in   synchronous parallel load (priority over counting)
//   din       in   [D*M-1:0] load value, digit i at din[i*M +: M]
//   qout      out  [D*M-1:0] counter value, digit i at qout[i*M +: M]
//   digit_tc  out  [D-1:0] carry/borrow out of each digit (combinational)
//   tc        out  chain terminal count, = digit_tc[D-1] (combinational)
//   load_err  out  registered: the last load had a digit >= N (clamped to N-1)
//
// Optional feature, enabled by defining COUNTER_CASCADE_MATCH_EN:
//   match_val in   [D*M-1:0] compare value
//   match     out  registered: high in the cycle where qout == match_val
module counter_cascade_n
    import counter_pkg::*;
#(
    parameter int unsigned N = 10,
    parameter int unsigned M = 4,
    parameter int unsigned D = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           up,
    input  logic           load,
    input  logic [D*M-1:0] din,
    output logic [D*M-1:0] qout,
    output logic [D-1:0]   digit_tc,
    output logic           tc,
    output logic           load_err
`ifdef COUNTER_CASCADE_MATCH_EN
    ,
    input  logic [D*M-1:0] match_val,
    output logic           match
`endif
);

    localparam logic [M-1:0] Max = M'(N - 1);

    if (N < 2 || D < 1 || !digit_width_ok(N, M)) begin : g_bad_params
        $error("counter_cascade_n: need N >= 2, D >= 1 and 2**M >= N");
    end

    // carry[i] is the count permission into digit i; carry[i+1] is digit i's
    // carry/borrow out. Folding load and reset into carry[0] suppresses every
    // terminal-count flag in those cycles without extra gating.
    logic [D:0]          carry;
    logic [D-1:0][M-1:0] digit_q;
    logic [D-1:0][M-1:0] digit_ld;
    logic [D-1:0]        clamp;
    logic [D-1:0]        wrap;

    assign carry[0] = enable & ~load & ~reset;

    for (genvar i = 0; i < D; i++) begin : g_digit
        logic [M-1:0] din_digit;

        assign din_digit   = din[i*M +: M];
        assign clamp[i]    = din_digit > Max;
        assign digit_ld[i] = clamp[i] ? Max : din_digit;

        counter_digit #(
            .N (N),
            .M (M)
        ) u_digit (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .ld_val (digit_ld[i]),
            .cin    (carry[i]),
            .up     (up),
            .q      (digit_q[i]),
            .cout   (wrap[i])
        );

        assign carry[i+1] = carry[i] & wrap[i];
    end

    assign qout     = digit_q;
    assign digit_tc = carry[D:1];
    assign tc       = carry[D];

    // load_err only changes on reset or load; plain counting leaves it alone.
    logic load_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else if (load) begin
            load_err_q <= |clamp;
        end
    end

    assign load_err = load_err_q;

`ifdef COUNTER_CASCADE_MATCH_EN
    // Compare against the value qout takes after this edge so that the
    // registered match lines up with qout in the same cycle.
    logic [D-1:0][M-1:0] digit_nxt;
    logic                match_q;

    for (genvar i = 0; i < D; i++) begin : g_nxt
        logic [M-1:0] nxt;

        always_comb begin
            nxt = digit_q[i];
            if (load) begin
                nxt = digit_ld[i];
            end else if (carry[i]) begin
                if (up == DirUp) begin
                    nxt = (digit_q[i] == Max) ? '0 : digit_q[i] + 1'b1;
                end else begin
                    nxt = (digit_q[i] == '0) ? Max : digit_q[i] - 1'b1;
                end
            end
        end

        assign digit_nxt[i] = nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (digit_nxt == match_val);
        end
    end

    assign match = match_q;
`endif

endmodule
